// File: rtl/psg_frac_cen_if.sv
// Ratio-load handshake for psg_frac_cen: ld is a one-cycle request carrying n_in/m_in and is
// ignored while busy is high; each accepted or rejected request ends with a one-cycle ld_ack (+ ld_err).
interface psg_frac_cen_if #(
  parameter int W = 12
);
  logic [W-1:0] n_in;
  logic [W-1:0] m_in;
  logic         ld;
  logic         busy;
  logic         ld_ack;
  logic         ld_err;

  modport master (
    output n_in, m_in, ld,
    input  busy, ld_ack, ld_err
  );

  modport slave (
    input  n_in, m_in, ld,
    output busy, ld_ack, ld_err
  );
endinterface

// File: rtl/psg_frac_cen.sv
// Fractional N/M clock-enable generator: a phase accumulator fires at rate 2N/M, with fires
// routed alternately to cen and cenb; a new ratio is applied only on a cenb boundary or while stopped.
module psg_frac_cen #(
  parameter int W     = 12,
  parameter int DEF_N = 1,
  parameter int DEF_M = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  psg_frac_cen_if.slave  lb,
  output logic           cen,
  output logic           cenb,
  output logic           dbg_state
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  localparam logic [W-1:0] N_RST = W'(DEF_N);
  localparam logic [W-1:0] M_RST = W'(DEF_M);

  state_t       state_q;
  state_t       state_d;

  logic [W-1:0] n_reg;
  logic [W-1:0] m_reg;
  logic [W-1:0] n_sh;
  logic [W-1:0] m_sh;
  logic [W:0]   acc;
  logic         phase;

  logic         cen_q;
  logic         cenb_q;
  logic         ld_ack_q;
  logic         ld_err_q;

  logic [W+1:0] sum;
  logic [W+1:0] diff;
  logic [W+1:0] acc_full;
  logic [W:0]   acc_nx;
  logic         fire;
  logic         apply;
  logic         req_ok;
  logic         capture;
  logic         ack_d;
  logic         err_d;
  logic         unused_top_bit;

  // Full-width step so 2N never wraps before the compare against M.
  assign sum      = {1'b0, acc} + {1'b0, n_reg, 1'b0};
  assign diff     = sum - {2'b00, m_reg};
  assign fire     = en && (sum >= {2'b00, m_reg});
  assign acc_full = fire ? diff : sum;
  assign acc_nx   = acc_full[W:0];
  assign unused_top_bit = acc_full[W+1];

  // 2*n_in is formed at W+1 bits so a large n_in cannot alias to a small value.
  assign req_ok = (lb.n_in != '0) && (lb.m_in != '0) &&
                  ({lb.n_in, 1'b0} <= {1'b0, lb.m_in});

  assign apply = (state_q == ST_PEND) && (!en || (fire && phase));

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (lb.ld) begin
          if (req_ok) begin
            capture = 1'b1;
            state_d = ST_PEND;
          end else begin
            ack_d = 1'b1;
            err_d = 1'b1;
          end
        end
      end
      ST_PEND: begin
        if (apply) begin
          ack_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_reg    <= N_RST;
      m_reg    <= M_RST;
      n_sh     <= N_RST;
      m_sh     <= M_RST;
      acc      <= '0;
      phase    <= 1'b0;
      cen_q    <= 1'b0;
      cenb_q   <= 1'b0;
      ld_ack_q <= 1'b0;
      ld_err_q <= 1'b0;
    end else begin
      cen_q    <= fire & ~phase;
      cenb_q   <= fire & phase;
      ld_ack_q <= ack_d;
      ld_err_q <= err_d;
      if (capture) begin
        n_sh <= lb.n_in;
        m_sh <= lb.m_in;
      end
      // The apply wins over this step's accumulator update; its cenb pulse still goes out.
      if (apply) begin
        n_reg <= n_sh;
        m_reg <= m_sh;
        acc   <= '0;
        phase <= 1'b0;
      end else if (en) begin
        acc   <= acc_nx;
        phase <= phase ^ fire;
      end
    end
  end

  assign cen       = cen_q;
  assign cenb      = cenb_q;
  assign lb.ld_ack = ld_ack_q;
  assign lb.ld_err = ld_err_q;
  assign lb.busy   = (state_q == ST_PEND);
  assign dbg_state = state_q;

endmodule

// File: doc/psg_frac_cen.md
# psg_frac_cen

Fractional clock-enable generator for the PSG clock tree. It derives the base `cen` strobe, plus a half-period-offset companion `cenb`, from the fast system clock at an exact N/M rate using a phase accumulator. It feeds the PSG's divide-by-16/256 enable stage. The N/M ratio can be reprogrammed at run time through a load/acknowledge handshake, and the new ratio only takes effect on a pulse-pair boundary, so the downstream tone and envelope counters never see a glitch.

## Interface
- `W`, 12: width of the N and M ratio fields.
- `DEF_N`, 1: N value loaded at reset.
- `DEF_M`, 8: M value loaded at reset. Must satisfy 0 < 2·DEF_N ≤ DEF_M.

- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `en`, in, 1: run enable. When low, the accumulator freezes and no pulses are generated.
- `n_in`, in, W: requested N.
- `m_in`, in, W: requested M.
- `ld`, in, 1: single-cycle load request. Ignored while `busy`=1.
- `busy`, out, 1: a load is pending.
- `ld_ack`, out, 1: one-cycle pulse when a load completes, either applied or rejected.
- `ld_err`, out, 1: one-cycle pulse together with `ld_ack` when the request was rejected.
- `cen`, out, 1: one-cycle strobe, average rate N/M per clk.
- `cenb`, out, 1: one-cycle strobe at rate N/M, interleaved with `cen`.

## Operation
- Registers: `n_reg`/`m_reg` (W bits), `acc` (W+1 bits), `phase` (1 bit), shadow `n_sh`/`m_sh`, `pend`.
- Reset values: `n_reg`=DEF_N, `m_reg`=DEF_M, `acc`=0, `phase`=0, `pend`=0. All outputs are 0.
- Step, on each clk with `en`=1:
  - sum = acc + 2·n_reg, computed at W+2 bits with no truncation.
  - If sum ≥ m_reg: fire, acc ← sum − m_reg, phase toggles.
  - Otherwise: acc ← sum.
- Fire routing:
  - phase=0 at fire time → `cen`.
  - phase=1 at fire time → `cenb`.
  - `cen` and `cenb` therefore strictly alternate, and `cen` and `cenb` are never high in the same cycle.
- Invariants:
  - acc < m_reg at all times.
  - At most one fire per clk.
  - When 2N = M, a fire occurs every clk, so `cen` strobes every 2 clk and `cenb` strobes in the cycles between.
- With `en`=0: acc and phase hold. `cen`/`cenb` are 0 in the following cycle.
- State machine:
  - IDLE (`pend`=0).
  - PEND (`pend`=1, `busy`=1).
- IDLE with `ld`=1: validate `n_in`/`m_in`. The request is valid iff n_in ≠ 0, m_in ≠ 0, and 2·n_in ≤ m_in, with the comparison done at W+1 bits.
  - Invalid: `ld_ack`=`ld_err`=1 in the next cycle. Ratio unchanged. Stay in IDLE.
  - Valid: capture into `n_sh`/`m_sh` and go to PEND.
- PEND, apply condition: `en`=0, or a `cenb` fire (phase=1) occurs in the current step.
  - On apply: n_reg ← n_sh, m_reg ← m_sh, acc ← 0, phase ← 0, `ld_ack`=1 next cycle, return to IDLE.
  - The apply overrides the acc/phase update of the fire step. The `cenb` pulse from that step is still emitted.
- `ld` while in PEND is ignored. It produces no ack and leaves the shadow registers unchanged.
- Reset in mid-PEND: the pending load is discarded and the DEF ratio is restored. No `ld_ack` is issued.

## Timing
- Output registers: `cen`, `cenb`, `ld_ack`, `ld_err`. `busy` is driven directly from `pend`.
- Latency: a fire computed on clk edge k appears as a pulse during cycle k+1.
- From reset release with `en`=1 and N=1, M=8, the first `cen` appears in the 4th cycle after the first active edge. Thereafter `cen` is every 8 clk and `cenb` is 4 clk after each `cen`.
- `ld` → `busy`=1 in the cycle after `ld`.
- Valid load with `en`=0: `ld_ack` 2 cycles after `ld`.
- Valid load with `en`=1: `ld_ack` is coincident with the pending `cenb`. The next `cen` follows the new ratio, with the accumulator starting from 0.
- `en` rising: stepping resumes on the same edge. There is no restart; the accumulator continues from its held value.

## Test plan
- Defaults (N=1, M=8), `en`=1, 80 clk → exactly 10 `cen` and 10 `cenb`. `cen`→`cenb` spacing is 4 clk and `cenb`→`cen` spacing is 4 clk. No overlap.
- Load N=3, M=16 with `en`=0, then run 160 clk → `ld_ack`=1 and `ld_err`=0; 30 `cen` and 30 `cenb`; strict alternation; no two consecutive `cen` without a `cenb` between them.
- Load N=4, M=8 → `cen` on every 2nd clk and `cenb` in the interleaved clks, sustained over 64 clk.
- Invalid loads N=5/M=8, N=0/M=8, N=1/M=0 → each gives `ld_ack`=`ld_err`=1 for one cycle. The default 8-clk `cen` period is unchanged.
- Running at defaults, `ld` N=1, M=4 → `busy` stays high until the next `cenb`, and `ld_ack` is coincident with that `cenb`. The next `cen` arrives 2 clk later and the period is then 4 clk. A second `ld` issued during `busy` is ignored.
- Assert `rst_n` low while in PEND → all outputs go to 0 immediately. After release there is no `ld_ack` and the DEF period of 8 clk resumes.
